ex_mem_pipe_reg: RTL and testbench
==================================

Name: ex_mem_pipe_reg

Overview:
Parametrised EX/MEM pipeline register: successor to the free-running EX/MEM latch. Adds valid/ready handshake, a 2-entry skid buffer for full throughput under backpressure, synchronous flush, and synchronous active-low reset. Sits between the EX stage (ALU, forwarding) and the MEM stage (data memory). Carries inst, MEM control, WB control, ALU result and RT store data.

Parameters:
INST_W, 32, instruction field width
MEM_W, 3, MEM-stage control width
WB_W, 2, WB-stage control width
DATA_W, 32, ALU result and RT data width

Ports:
clk_i  in  1  clock; all state updates on posedge
rst_n_i  in  1  reset; synchronous, active-low
flush_i  in  1  synchronous kill of all held entries
in_valid_i  in  1  EX presents a valid bundle
in_ready_o  out  1  stage can accept this cycle; registered
inst_i  in  INST_W  instruction
MEM_signal_i  in  MEM_W  MEM control
WB_signal_i  in  WB_W  WB control
ALUResult_i  in  DATA_W  ALU result
RTdata_i  in  DATA_W  store data
out_valid_o  out  1  MEM-side bundle valid
out_ready_i  in  1  MEM stage accepts
inst_o, MEM_signal_o, WB_signal_o, ALUResult_o, RTdata_o  out  as inputs  registered payload

Behaviour:
- Payload PW = INST_W+MEM_W+WB_W+2*DATA_W, packed {inst, mem, wb, alu, rt}. Two regs: main (drives outputs), skid.
- in_fire = in_valid_i & in_ready_o; out_fire = out_valid_o & out_ready_i.
- States: EMPTY (out_valid_o=0), ONE (main valid, skid empty), TWO (both valid). in_ready_o = 1 in EMPTY/ONE, 0 in TWO; registered from next state.
- EMPTY: in_fire -> ONE, main<=in.
- ONE: in_fire & out_fire -> ONE, main<=in; in_fire & !out_ready_i -> TWO, skid<=in; !in_fire & out_fire -> EMPTY; else hold.
- TWO: out_ready_i -> ONE, main<=skid; else hold. No input accepted.
- Latency: 1 cycle in->out when unstalled. Throughput 1 bundle/cycle with out_ready_i held high.
- Stability: while out_valid_o & !out_ready_i, all outputs hold exactly.
- Ordering: strict FIFO; skid never bypasses main.
- flush_i: next state EMPTY, in_ready_o=1 next cycle. Bundle offered in the flush cycle is discarded even if in_fire. Flush takes priority over every transition. out_fire in the flush cycle still counts as delivered.
- Reset (rst_n_i=0 at posedge): state EMPTY, out_valid_o=0, in_ready_o=1, main and skid all zero. Reset beats flush and handshakes. Reset mid-operation drops both entries.
- Widths pass through unmodified; no arithmetic.

Optional Feature:
EXMEM_BUBBLE_CLR_EN
- Defined: MEM_signal_o and WB_signal_o are forced to 0 whenever out_valid_o=0. Legacy MEM/WB logic that ignores valid then sees a NOP.
- Undefined: all outputs show main's last contents regardless of valid; consumer must qualify with out_valid_o.
- inst_o, ALUResult_o and RTdata_o are never gated.

Decomposition:
- Shared package cpu_pipe_pkg: default width constants (INST_W, MEM_W, WB_W, DATA_W); the state enum {EMPTY, ONE, TWO}; the bundle pack/unpack typedef.
- Sub-module pipe_skid_buf(PW): generic 2-entry handshake skid with flush. ex_mem_pipe_reg = pack, instance, unpack, plus bubble gating.
- pipe_skid_buf is reused later for IF/ID, ID/EX and MEM/WB.

Test Plan:
- Reset: hold rst_n_i=0 for 2 cycles with in_valid_i=1 -> out_valid_o=0, all outputs 0, in_ready_o=1; first bundle accepted only after release.
- Streaming: 8 bundles ALUResult_i=0x10..0x17, out_ready_i=1 -> each appears 1 cycle later in order; in_ready_o stays 1.
- Backpressure: send 0xA, 0xB with out_ready_i=0 -> state TWO, in_ready_o=0, outputs hold 0xA. Raise ready -> 0xA then 0xB; no loss or duplication.
- Flush in TWO with in_valid_i=1 (0xC) -> next cycle out_valid_o=0, in_ready_o=1; 0xA, 0xB, 0xC never appear.
- Random valid/ready, 1000 bundles -> scoreboard exact order; outputs stable during every stall.
- With EXMEM_BUBBLE_CLR_EN: after the last bundle drains (MEM=3'b101, WB=2'b11) -> MEM_signal_o=0, WB_signal_o=0. Without the macro: they hold 3'b101/2'b11.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions: default field widths, skid buffer state
// encoding and the default-width EX/MEM bundle layout.
package cpu_pipe_pkg;

    localparam int DEFAULT_INST_W = 32;
    localparam int DEFAULT_MEM_W  = 3;
    localparam int DEFAULT_WB_W   = 2;
    localparam int DEFAULT_DATA_W = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

    // Packing order is {inst, mem, wb, alu, rt}, MSB first.
    typedef struct packed {
        logic [DEFAULT_INST_W-1:0] inst;
        logic [DEFAULT_MEM_W-1:0]  mem;
        logic [DEFAULT_WB_W-1:0]   wb;
        logic [DEFAULT_DATA_W-1:0] alu;
        logic [DEFAULT_DATA_W-1:0] rt;
    } ex_mem_bundle_t;

    localparam int EX_MEM_BUNDLE_W = $bits(ex_mem_bundle_t);

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with synchronous flush.
// main drives the output; skid catches the one bundle accepted in the
// cycle the consumer stalls, so in_ready can be a plain register.
//
// state | meaning
// EMPTY | nothing held, out_valid low
// ONE   | main valid, skid empty
// TWO   | main and skid valid, input blocked
module pipe_skid_buf
    import cpu_pipe_pkg::*;
#(
    parameter int PW = 8
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          flush_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [PW-1:0] in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [PW-1:0] out_data_o
);

    skid_state_e   state;
    skid_state_e   state_next;
    logic          in_ready_q;
    logic [PW-1:0] main_q;
    logic [PW-1:0] skid_q;
    logic          in_fire;
    logic          out_fire;
    logic          main_load;
    logic          main_from_skid;
    logic          skid_load;

    // State register; in_ready is registered from the next state.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state      <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_next;
            in_ready_q <= (state_next != TWO);
        end
    end

    // Next-state logic; flush overrides every handshake transition.
    always_comb begin
        state_next = state;
        if (flush_i) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: if (in_fire) state_next = ONE;
                ONE: begin
                    if (in_fire && !out_ready_i)
                        state_next = TWO;
                    else if (!in_fire && out_fire)
                        state_next = EMPTY;
                end
                TWO:     if (out_ready_i) state_next = ONE;
                default: state_next = EMPTY;
            endcase
        end
    end

    // Handshake outputs and datapath load enables.
    always_comb begin
        out_valid_o    = (state != EMPTY);
        in_fire        = in_valid_i & in_ready_q;
        out_fire       = out_valid_o & out_ready_i;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        if (!flush_i) begin
            case (state)
                EMPTY: main_load = in_fire;
                ONE: begin
                    main_load = in_fire & out_ready_i;
                    skid_load = in_fire & ~out_ready_i;
                end
                TWO: begin
                    main_load      = out_ready_i;
                    main_from_skid = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Payload registers; skid only ever refills main, never the output.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (main_load)
                main_q <= main_from_skid ? skid_q : in_data_i;
            if (skid_load)
                skid_q <= in_data_i;
        end
    end

    assign in_ready_o = in_ready_q;
    assign out_data_o = main_q;

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register with valid/ready handshake, skid buffer and
// flush. Optional macro EXMEM_BUBBLE_CLR_EN zeroes the MEM and WB control
// outputs while no bundle is valid, so legacy consumers see a NOP.
module ex_mem_pipe_reg
    import cpu_pipe_pkg::*;
#(
    parameter int INST_W = DEFAULT_INST_W,
    parameter int MEM_W  = DEFAULT_MEM_W,
    parameter int WB_W   = DEFAULT_WB_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [INST_W-1:0] inst_i,
    input  logic [MEM_W-1:0]  MEM_signal_i,
    input  logic [WB_W-1:0]   WB_signal_i,
    input  logic [DATA_W-1:0] ALUResult_i,
    input  logic [DATA_W-1:0] RTdata_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [INST_W-1:0] inst_o,
    output logic [MEM_W-1:0]  MEM_signal_o,
    output logic [WB_W-1:0]   WB_signal_o,
    output logic [DATA_W-1:0] ALUResult_o,
    output logic [DATA_W-1:0] RTdata_o
);

    localparam int PW = INST_W + MEM_W + WB_W + 2 * DATA_W;

    logic [PW-1:0]     in_data;
    logic [PW-1:0]     out_data;
    logic [MEM_W-1:0]  mem_held;
    logic [WB_W-1:0]   wb_held;

    assign in_data = {inst_i, MEM_signal_i, WB_signal_i, ALUResult_i, RTdata_i};

    pipe_skid_buf #(
        .PW (PW)
    ) u_skid (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data)
    );

    assign {inst_o, mem_held, wb_held, ALUResult_o, RTdata_o} = out_data;

`ifdef EXMEM_BUBBLE_CLR_EN
    assign MEM_signal_o = out_valid_o ? mem_held : '0;
    assign WB_signal_o  = out_valid_o ? wb_held  : '0;
`else
    assign MEM_signal_o = mem_held;
    assign WB_signal_o  = wb_held;
`endif

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Directed-vector and scoreboard bench for ex_mem_pipe_reg.
module tb_ex_mem_pipe_reg;

`ifdef EXMEM_BUBBLE_CLR_EN
    localparam bit BUB = 1'b1;
`else
    localparam bit BUB = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] inst_in;
    logic [2:0]  mem_in;
    logic [1:0]  wb_in;
    logic [31:0] alu_in;
    logic [31:0] rt_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] inst_out;
    logic [2:0]  mem_out;
    logic [1:0]  wb_out;
    logic [31:0] alu_out;
    logic [31:0] rt_out;

    int n_cmp  = 0;
    int n_fail = 0;

    ex_mem_pipe_reg dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .flush_i      (flush),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .inst_i       (inst_in),
        .MEM_signal_i (mem_in),
        .WB_signal_i  (wb_in),
        .ALUResult_i  (alu_in),
        .RTdata_i     (rt_in),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .inst_o       (inst_out),
        .MEM_signal_o (mem_out),
        .WB_signal_o  (wb_out),
        .ALUResult_o  (alu_out),
        .RTdata_o     (rt_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All payload fields are derived from the ALU value so one number
    // identifies a bundle; zero maps to an all-zero bundle.
    function automatic logic [31:0] f_inst(input logic [31:0] a);
        return {a[15:0], a[15:0]};
    endfunction
    function automatic logic [31:0] f_rt(input logic [31:0] a);
        return {a[7:0], a[31:8]};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic iv,
                         input logic ordy, input logic [31:0] a);
        rst_n     = r;
        flush     = f;
        in_valid  = iv;
        out_ready = ordy;
        alu_in    = a;
        inst_in   = f_inst(a);
        rt_in     = f_rt(a);
        mem_in    = a[2:0];
        wb_in     = a[4:3];
    endtask

    typedef struct {
        logic        rst_n;
        logic        flush;
        logic        in_valid;
        logic        out_ready;
        logic [31:0] alu;
        logic        exp_ov;
        logic        exp_ir;
        logic [31:0] exp_alu;
    } vec_t;

    vec_t vec[28];

    logic [31:0] sb[$];
    logic [31:0] next_val;
    logic [31:0] exp_front;
    logic [31:0] p_alu, p_inst, p_rt;
    logic [2:0]  p_mem;
    logic [1:0]  p_wb;
    logic        p_ov;
    logic        stall;
    logic        ifire, ofire;
    int          sent;
    int          cycles;

    initial begin
        //            rst  fl  iv  or   alu        ov  ir  exp_alu
        vec[0]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h99, 1'b0, 1'b1, 32'h0};
        vec[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h99, 1'b0, 1'b1, 32'h0};
        for (int i = 0; i < 8; i++)
            vec[2+i] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h10 + i, 1'b1, 1'b1, 32'h10 + i};
        vec[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0,  1'b0, 1'b1, 32'h17};
        vec[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'hA,  1'b1, 1'b1, 32'hA};
        vec[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'hB,  1'b1, 1'b0, 32'hA};
        vec[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'hE,  1'b1, 1'b0, 32'hA};
        vec[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0,  1'b1, 1'b1, 32'hB};
        vec[15] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0,  1'b0, 1'b1, 32'hB};
        vec[16] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'hA,  1'b1, 1'b1, 32'hA};
        vec[17] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'hB,  1'b1, 1'b0, 32'hA};
        vec[18] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'hC,  1'b0, 1'b1, 32'hA};
        vec[19] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0,  1'b0, 1'b1, 32'hA};
        vec[20] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h20, 1'b1, 1'b1, 32'h20};
        vec[21] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h21, 1'b0, 1'b1, 32'h20};
        vec[22] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h30, 1'b1, 1'b1, 32'h30};
        vec[23] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h31, 1'b1, 1'b0, 32'h30};
        vec[24] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h32, 1'b0, 1'b1, 32'h0};
        vec[25] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0,  1'b0, 1'b1, 32'h0};
        vec[26] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h5D, 1'b1, 1'b1, 32'h5D};
        vec[27] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0,  1'b0, 1'b1, 32'h5D};

        for (int i = 0; i < 28; i++) begin
            drive(vec[i].rst_n, vec[i].flush, vec[i].in_valid, vec[i].out_ready, vec[i].alu);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d out_valid", i), 64'(out_valid), 64'(vec[i].exp_ov));
            chk($sformatf("v%0d in_ready", i),  64'(in_ready),  64'(vec[i].exp_ir));
            chk($sformatf("v%0d alu", i),  64'(alu_out),  64'(vec[i].exp_alu));
            chk($sformatf("v%0d inst", i), 64'(inst_out), 64'(f_inst(vec[i].exp_alu)));
            chk($sformatf("v%0d rt", i),   64'(rt_out),   64'(f_rt(vec[i].exp_alu)));
            chk($sformatf("v%0d mem", i),  64'(mem_out),
                64'((vec[i].exp_ov || !BUB) ? vec[i].exp_alu[2:0] : 3'b000));
            chk($sformatf("v%0d wb", i),   64'(wb_out),
                64'((vec[i].exp_ov || !BUB) ? vec[i].exp_alu[4:3] : 2'b00));
        end

        // Randomised valid/ready against a FIFO scoreboard.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        next_val = 32'h1000;
        sent     = 0;
        cycles   = 0;
        stall    = 1'b0;
        while ((sent < 1000 || sb.size() != 0 || out_valid) && cycles < 20000) begin
            if (stall) begin
                chk("stall_valid", 64'(out_valid), 64'(p_ov));
                chk("stall_alu",   64'(alu_out),   64'(p_alu));
                chk("stall_inst",  64'(inst_out),  64'(p_inst));
                chk("stall_rt",    64'(rt_out),    64'(p_rt));
                chk("stall_ctl",   64'({mem_out, wb_out}), 64'({p_mem, p_wb}));
            end
            drive(1'b1, 1'b0, (sent < 1000) && ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 2) != 0, next_val);
            ifire = in_valid & in_ready;
            ofire = out_valid & out_ready;
            if (ofire) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 64'(alu_out), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    exp_front = sb.pop_front();
                    chk("sb_alu",  64'(alu_out),  64'(exp_front));
                    chk("sb_inst", 64'(inst_out), 64'(f_inst(exp_front)));
                end
            end
            if (ifire) begin
                sb.push_back(next_val);
                next_val = next_val + 1;
                sent++;
            end
            stall  = out_valid & ~out_ready;
            p_ov   = out_valid;
            p_alu  = alu_out;
            p_inst = inst_out;
            p_rt   = rt_out;
            p_mem  = mem_out;
            p_wb   = wb_out;
            @(posedge clk);
            #1;
            cycles++;
        end
        chk("random_timeout", 64'(cycles < 20000), 64'(1));
        chk("random_sent", 64'(sent), 64'(1000));
        chk("random_left", 64'(sb.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
